pmem_arbiter_n: RTL and testbench

Parametrised N-port physical-memory arbiter. It serialises line-sized read and write requests from `NUM_PORTS` cache-side requesters onto a single pmem interface, using either fixed-priority or round-robin grant. It latches the granted request so pmem sees stable signals for the whole transaction, and it returns read data through a per-port registered buffer. It sits between the L1 caches (or an L2) and physical memory, and is the generalised successor of the two-port I/D arbiter.

---
 rtl/pmem_arbiter_n.sv | 140 ++++++++++++++
 tb/tb_pmem_arbiter_n.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter_n.sv
// rtl/pmem_arbiter_n.sv - N-port line-sized pmem arbiter with fixed-priority or round-robin grant
// The granted request is latched into the output registers so pmem sees it stable until pmem_resp.
module pmem_arbiter_n #(
  parameter int  NUM_PORTS   = 2,
  parameter int  LINE_WIDTH  = 128,
  parameter int  ADDR_WIDTH  = 16,
  parameter int  ROUND_ROBIN = 1,
  localparam int IDX_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            port_read,
  input  logic [NUM_PORTS-1:0]            port_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_address,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0] port_wdata,
  output logic [NUM_PORTS-1:0]            port_resp,
  output logic [NUM_PORTS*LINE_WIDTH-1:0] port_rdata,
  input  logic                            pmem_resp,
  input  logic [LINE_WIDTH-1:0]           pmem_rdata,
  output logic                            pmem_read,
  output logic                            pmem_write,
  output logic [ADDR_WIDTH-1:0]           pmem_address,
  output logic [LINE_WIDTH-1:0]           pmem_wdata,
  output logic [IDX_W-1:0]                grant_idx
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                          r_state;
  logic [IDX_W-1:0]                r_ptr;
  logic [IDX_W-1:0]                r_grant;
  logic                            r_pmem_read;
  logic                            r_pmem_write;
  logic [ADDR_WIDTH-1:0]           r_pmem_address;
  logic [LINE_WIDTH-1:0]           r_pmem_wdata;
  logic [NUM_PORTS-1:0]            r_port_resp;
  logic [NUM_PORTS*LINE_WIDTH-1:0] r_rdata;

  logic [NUM_PORTS-1:0]            w_req;
  logic                            w_any;
  logic                            w_found;
  logic [IDX_W-1:0]                w_grant;
  logic [IDX_W-1:0]                w_ptr_next;
  logic                            w_sel_read;
  logic [ADDR_WIDTH-1:0]           w_sel_addr;
  logic [LINE_WIDTH-1:0]           w_sel_wdata;

  // Round-robin: first requester at distance 0,1,.. above r_ptr; fixed: highest index wins.
  always_comb begin
    w_req   = port_read | port_write;
    w_any   = |w_req;
    w_found = 1'b0;
    w_grant = '0;
    if (ROUND_ROBIN != 0) begin
      for (int off = 0; off < NUM_PORTS; off++) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (!w_found && w_req[i] && (((int'(r_ptr) + off) % NUM_PORTS) == i)) begin
            w_found = 1'b1;
            w_grant = IDX_W'(i);
          end
        end
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_req[i]) w_grant = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_sel_read  = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_grant == IDX_W'(i)) begin
        w_sel_read  = port_read[i];
        w_sel_addr  = port_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = port_wdata[i*LINE_WIDTH +: LINE_WIDTH];
      end
    end
  end

  assign w_ptr_next = (w_grant == IDX_W'(NUM_PORTS - 1)) ? '0 : w_grant + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_ptr          <= '0;
      r_grant        <= '0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
      r_port_resp    <= '0;
      r_rdata        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant        <= w_grant;
            r_ptr          <= w_ptr_next;
            r_pmem_read    <= w_sel_read;
            r_pmem_write   <= ~w_sel_read;
            r_pmem_address <= w_sel_addr;
            r_pmem_wdata   <= w_sel_wdata;
            r_state        <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (pmem_resp) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
              if (r_pmem_read && (r_grant == IDX_W'(i)))
                r_rdata[i*LINE_WIDTH +: LINE_WIDTH] <= pmem_rdata;
              r_port_resp[i] <= (r_grant == IDX_W'(i));
            end
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
            r_state        <= S_DONE;
          end
        end
        S_DONE: begin
          r_port_resp <= '0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign port_resp    = r_port_resp;
  assign port_rdata   = r_rdata;
  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;
  assign grant_idx    = r_grant;

endmodule

// File: tb/tb_pmem_arbiter_n.sv
// tb/tb_pmem_arbiter_n.sv - scoreboard bench for pmem_arbiter_n, round-robin and fixed-priority instances
module tb_pmem_arbiter_n;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   port_read;
  logic [3:0]   port_write;
  logic [63:0]  port_address;
  logic [511:0] port_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  logic [3:0]   rr_port_resp, fp_port_resp;
  logic [511:0] rr_port_rdata, fp_port_rdata;
  logic         rr_pmem_read, fp_pmem_read, rr_pmem_write, fp_pmem_write;
  logic [15:0]  rr_pmem_address, fp_pmem_address;
  logic [127:0] rr_pmem_wdata, fp_pmem_wdata;
  logic [1:0]   rr_grant_idx, fp_grant_idx;

  int checks = 0;
  int errors = 0;
  int           sb_port[$];
  logic [127:0] sb_data[$];

  always #5 clk = ~clk;

  pmem_arbiter_n #(.NUM_PORTS(4), .LINE_WIDTH(128), .ADDR_WIDTH(16), .ROUND_ROBIN(1)) u_rr (
    .clk(clk), .reset(reset),
    .port_read(port_read), .port_write(port_write),
    .port_address(port_address), .port_wdata(port_wdata),
    .port_resp(rr_port_resp), .port_rdata(rr_port_rdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .pmem_read(rr_pmem_read), .pmem_write(rr_pmem_write),
    .pmem_address(rr_pmem_address), .pmem_wdata(rr_pmem_wdata),
    .grant_idx(rr_grant_idx)
  );

  pmem_arbiter_n #(.NUM_PORTS(4), .LINE_WIDTH(128), .ADDR_WIDTH(16), .ROUND_ROBIN(0)) u_fp (
    .clk(clk), .reset(reset),
    .port_read(port_read), .port_write(port_write),
    .port_address(port_address), .port_wdata(port_wdata),
    .port_resp(fp_port_resp), .port_rdata(fp_port_rdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .pmem_read(fp_pmem_read), .pmem_write(fp_pmem_write),
    .pmem_address(fp_pmem_address), .pmem_wdata(fp_pmem_wdata),
    .grant_idx(fp_grant_idx)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    port_read = '0; port_write = '0; port_address = '0; port_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    reset = 1'b1;
    tick();
    checks++; if (rr_port_rdata !== '0 || fp_port_rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rr_port_rdata[127:0]); end
    checks++; if ({rr_pmem_read, rr_pmem_write, rr_port_resp} !== 6'b0) begin errors++; $display("FAIL reset_strobes got %b exp 0", {rr_pmem_read, rr_pmem_write, rr_port_resp}); end
    checks++; if (rr_pmem_address !== 16'h0 || rr_pmem_wdata !== '0 || rr_grant_idx !== 2'd0) begin errors++; $display("FAIL reset_addr got %h/%0d exp 0/0", rr_pmem_address, rr_grant_idx); end
    reset = 1'b0;
    tick();
    checks++; if ({fp_pmem_read, fp_pmem_write, fp_port_resp, fp_grant_idx} !== 8'b0) begin errors++; $display("FAIL reset_idle got %b exp 0", {fp_pmem_read, fp_pmem_write, fp_port_resp, fp_grant_idx}); end
  endtask

  task automatic test_single_read();
    logic [127:0] d, ed;
    int ep;
    d = {16{8'hA5}};
    port_read[0] = 1'b1; port_address[15:0] = 16'h1230;
    sb_port.push_back(0); sb_data.push_back(d);
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++; if (rr_pmem_read !== 1'b1 || rr_pmem_write !== 1'b0 || rr_pmem_address !== 16'h1230) begin errors++; $display("FAIL rd_strobe_c%0d got r%b w%b a%h exp r1 w0 a1230", c, rr_pmem_read, rr_pmem_write, rr_pmem_address); end
      if (c == 3) begin pmem_resp = 1'b1; pmem_rdata = d; end
    end
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0;
    ep = sb_port.pop_front(); ed = sb_data.pop_front();
    checks++; if (rr_port_resp !== (4'b1 << ep)) begin errors++; $display("FAIL rd_resp got %b exp %b", rr_port_resp, 4'b1 << ep); end
    checks++; if (rr_port_rdata[ep*128 +: 128] !== ed) begin errors++; $display("FAIL rd_data got %h exp %h", rr_port_rdata[ep*128 +: 128], ed); end
    checks++; if (rr_port_rdata[255:128] !== '0 || rr_pmem_read !== 1'b0) begin errors++; $display("FAIL rd_other got %h r%b exp 0 r0", rr_port_rdata[255:128], rr_pmem_read); end
    port_read[0] = 1'b0;
    tick();
    checks++; if (rr_port_resp !== 4'b0 || rr_pmem_read !== 1'b0) begin errors++; $display("FAIL rd_pulse got %b r%b exp 0 r0", rr_port_resp, rr_pmem_read); end
  endtask

  task automatic test_single_write();
    logic [127:0] w, ed;
    int ep;
    w = 128'hDEAD_0011_2233_4455_6677_8899_AABB_BEEF;
    port_write[1] = 1'b1; port_address[31:16] = 16'h0040; port_wdata[255:128] = w;
    sb_port.push_back(1); sb_data.push_back(128'h0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++; if (rr_pmem_write !== 1'b1 || rr_pmem_read !== 1'b0 || rr_pmem_address !== 16'h0040 || rr_pmem_wdata !== w) begin errors++; $display("FAIL wr_hold_c%0d got w%b r%b a%h d%h exp w1 r0 a0040 d%h", c, rr_pmem_write, rr_pmem_read, rr_pmem_address, rr_pmem_wdata, w); end
      if (c == 2) begin port_address[31:16] = 16'hFFFF; port_wdata[255:128] = ~w; end
      if (c == 4) begin pmem_resp = 1'b1; pmem_rdata = {16{8'h5A}}; end
    end
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0;
    ep = sb_port.pop_front(); ed = sb_data.pop_front();
    checks++; if (rr_port_resp !== (4'b1 << ep)) begin errors++; $display("FAIL wr_resp got %b exp %b", rr_port_resp, 4'b1 << ep); end
    checks++; if (rr_port_rdata[ep*128 +: 128] !== ed) begin errors++; $display("FAIL wr_no_load got %h exp %h", rr_port_rdata[ep*128 +: 128], ed); end
    checks++; if (rr_port_rdata[127:0] !== {16{8'hA5}}) begin errors++; $display("FAIL wr_keep_p0 got %h exp a5..", rr_port_rdata[127:0]); end
    port_write[1] = 1'b0; port_address = '0; port_wdata = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [127:0] d, ed;
    int ep, want;
    apply_reset();
    port_read = 4'hF;
    port_address = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
    for (int t = 0; t < 5; t++) begin
      want = t % 4;
      d = {4{32'hC0DE_0000 + 32'(t)}};
      sb_port.push_back(want); sb_data.push_back(d);
      tick();
      checks++; if (rr_grant_idx !== 2'(want) || rr_pmem_address !== (16'h0100 + 16'(want))) begin errors++; $display("FAIL rr_grant_t%0d got %0d a%h exp %0d", t, rr_grant_idx, rr_pmem_address, want); end
      checks++; if (fp_grant_idx !== 2'd3) begin errors++; $display("FAIL fp_highest_t%0d got %0d exp 3", t, fp_grant_idx); end
      pmem_resp = 1'b1; pmem_rdata = d;
      tick();
      pmem_resp = 1'b0;
      ep = sb_port.pop_front(); ed = sb_data.pop_front();
      checks++; if (rr_port_resp !== (4'b1 << ep) || rr_port_rdata[ep*128 +: 128] !== ed) begin errors++; $display("FAIL rr_resp_t%0d got %b %h exp %b %h", t, rr_port_resp, rr_port_rdata[ep*128 +: 128], 4'b1 << ep, ed); end
      tick();
      checks++; if (rr_pmem_read !== 1'b0 || rr_port_resp !== 4'b0) begin errors++; $display("FAIL rr_gap_t%0d got r%b resp%b exp 0", t, rr_pmem_read, rr_port_resp); end
    end
    port_read = '0;
    tick();
  endtask

  task automatic test_fixed_priority();
    int order[3] = '{2, 2, 0};
    logic [127:0] d, ed;
    int ep;
    apply_reset();
    port_read = 4'b0101;
    port_address[15:0] = 16'h0A00; port_address[47:32] = 16'h0A20;
    for (int t = 0; t < 3; t++) begin
      d = {4{32'hF1F0_0000 + 32'(t)}};
      sb_port.push_back(order[t]); sb_data.push_back(d);
      tick();
      checks++; if (fp_grant_idx !== 2'(order[t]) || fp_pmem_address !== (16'h0A00 + 16'(order[t] * 16))) begin errors++; $display("FAIL fp_grant_t%0d got %0d a%h exp %0d", t, fp_grant_idx, fp_pmem_address, order[t]); end
      tick();
      pmem_resp = 1'b1; pmem_rdata = d;
      tick();
      pmem_resp = 1'b0;
      ep = sb_port.pop_front(); ed = sb_data.pop_front();
      checks++; if (fp_port_resp !== (4'b1 << ep) || fp_port_rdata[ep*128 +: 128] !== ed) begin errors++; $display("FAIL fp_resp_t%0d got %b %h exp %b %h", t, fp_port_resp, fp_port_rdata[ep*128 +: 128], 4'b1 << ep, ed); end
      if (t == 1) port_read[2] = 1'b0;
      if (t == 2) port_read[0] = 1'b0;
      tick();
    end
  endtask

  task automatic test_read_write_same();
    logic [127:0] d, ed;
    int ep;
    apply_reset();
    d = {8{16'h1E1E}};
    port_read[1] = 1'b1; port_write[1] = 1'b1; port_address[31:16] = 16'h0777;
    sb_port.push_back(1); sb_data.push_back(d);
    for (int c = 1; c <= 2; c++) begin
      tick();
      checks++; if (rr_pmem_read !== 1'b1 || rr_pmem_write !== 1'b0 || rr_pmem_address !== 16'h0777) begin errors++; $display("FAIL rw_op_c%0d got r%b w%b a%h exp r1 w0 a0777", c, rr_pmem_read, rr_pmem_write, rr_pmem_address); end
    end
    pmem_resp = 1'b1; pmem_rdata = d;
    tick();
    pmem_resp = 1'b0;
    ep = sb_port.pop_front(); ed = sb_data.pop_front();
    checks++; if (rr_port_resp !== (4'b1 << ep) || rr_port_rdata[ep*128 +: 128] !== ed || rr_pmem_write !== 1'b0) begin errors++; $display("FAIL rw_resp got %b %h w%b exp %b %h w0", rr_port_resp, rr_port_rdata[ep*128 +: 128], rr_pmem_write, 4'b1 << ep, ed); end
    port_read = '0; port_write = '0;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] d, ed;
    int ep;
    apply_reset();
    d = {4{32'h1111_2222}};
    port_read[1] = 1'b1; port_address[31:16] = 16'h0011;
    sb_port.push_back(1); sb_data.push_back(d);
    tick();
    pmem_resp = 1'b1; pmem_rdata = d;
    tick();
    pmem_resp = 1'b0;
    ep = sb_port.pop_front(); ed = sb_data.pop_front();
    checks++; if (rr_port_resp !== (4'b1 << ep) || rr_port_rdata[ep*128 +: 128] !== ed) begin errors++; $display("FAIL mr_pre_resp got %b %h exp %b %h", rr_port_resp, rr_port_rdata[ep*128 +: 128], 4'b1 << ep, ed); end
    port_read = '0;
    tick();
    port_read[2] = 1'b1; port_address[47:32] = 16'h0022;
    tick();
    checks++; if (rr_pmem_read !== 1'b1 || rr_grant_idx !== 2'd2) begin errors++; $display("FAIL mr_busy got r%b g%0d exp r1 g2", rr_pmem_read, rr_grant_idx); end
    tick();
    reset = 1'b1; pmem_resp = 1'b1; pmem_rdata = {16{8'hEE}};
    tick();
    reset = 1'b0; port_read = '0;
    checks++; if (rr_pmem_read !== 1'b0 || rr_pmem_write !== 1'b0 || rr_pmem_address !== 16'h0) begin errors++; $display("FAIL mr_strobe got r%b w%b a%h exp 0", rr_pmem_read, rr_pmem_write, rr_pmem_address); end
    checks++; if (rr_grant_idx !== 2'd0 || rr_port_rdata !== '0 || rr_port_resp !== 4'b0) begin errors++; $display("FAIL mr_cleared got g%0d d%h resp%b exp 0", rr_grant_idx, rr_port_rdata[255:128], rr_port_resp); end
    tick();
    pmem_resp = 1'b0;
    checks++; if (rr_port_resp !== 4'b0 || rr_pmem_read !== 1'b0) begin errors++; $display("FAIL mr_late_resp got %b r%b exp 0", rr_port_resp, rr_pmem_read); end
    d = {4{32'h3333_4444}};
    port_read = 4'b1010; port_address[31:16] = 16'h0111; port_address[63:48] = 16'h0333;
    sb_port.push_back(1); sb_data.push_back(d);
    tick();
    checks++; if (rr_grant_idx !== 2'd1 || rr_pmem_address !== 16'h0111) begin errors++; $display("FAIL mr_ptr0 got g%0d a%h exp g1 a0111", rr_grant_idx, rr_pmem_address); end
    pmem_resp = 1'b1; pmem_rdata = d;
    tick();
    pmem_resp = 1'b0;
    ep = sb_port.pop_front(); ed = sb_data.pop_front();
    checks++; if (rr_port_resp !== (4'b1 << ep) || rr_port_rdata[ep*128 +: 128] !== ed) begin errors++; $display("FAIL mr_post_resp got %b %h exp %b %h", rr_port_resp, rr_port_rdata[ep*128 +: 128], 4'b1 << ep, ed); end
    port_read = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_fixed_priority();
    test_read_write_same();
    test_reset_mid_busy();
    checks++; if (sb_port.size() !== 0) begin errors++; $display("FAIL sb_drain got %0d exp 0", sb_port.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
